// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the elastic pipeline stage register.
package pipe_stage_pkg;

  // Selectors for the SKID parameter of pipe_stage.
  localparam int unsigned PIPE_SKID_OFF = 0;
  localparam int unsigned PIPE_SKID_ON  = 1;

  // Number of slots currently holding a payload.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage.sv
// Elastic pipeline stage register with valid/ready handshake, pause and flush.
// SKID=0: one slot, combinational in_ready. SKID=1: two slots, registered in_ready.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  FLUSH_DATA = '0,
  parameter int unsigned       SKID       = PIPE_SKID_ON
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pause,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             occ_q;
  occ_e             occ_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             rel;

  assign out_valid = (occ_q != OCC_EMPTY) && !pause && !flush;
  assign accept    = in_valid && in_ready;
  assign rel       = out_valid && out_ready;
  assign out_data  = head_q;
  assign occupancy = occ_q;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Occupancy next state: flush beats pause beats handshakes.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else if (pause) begin
      occ_d = occ_q;
    end else if (accept && !rel) begin
      occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
    end else if (rel && !accept) begin
      occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
    end
  end

  // Head slot: loads on accept into an empty stage or on pass-through,
  // otherwise advances from the skid slot when the head is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= FLUSH_DATA;
    end else if (flush) begin
      head_q <= FLUSH_DATA;
    end else if (!pause) begin
      if (accept && (rel || occ_q == OCC_EMPTY)) head_q <= in_data;
      else if (rel)                              head_q <= skid_data;
    end
  end

  generate
    if (SKID == PIPE_SKID_ON) begin : g_skid
      logic [WIDTH-1:0] skid_q;

      // in_ready depends only on registered occupancy, pause and flush.
      assign in_ready  = (occ_q != OCC_TWO) && !pause && !flush;
      assign skid_data = skid_q;

      // Skid slot: catches a payload arriving while head is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_q <= FLUSH_DATA;
        end else if (flush) begin
          skid_q <= FLUSH_DATA;
        end else if (!pause) begin
          if (accept && !rel && occ_q != OCC_EMPTY) skid_q <= in_data;
          else if (rel && !accept)                  skid_q <= FLUSH_DATA;
        end
      end
    end else begin : g_noskid
      // Without a skid slot the head refills straight from in_data, so a
      // released head falls back to FLUSH_DATA when nothing replaces it.
      assign in_ready  = ((occ_q == OCC_EMPTY) || out_ready) && !pause && !flush;
      assign skid_data = FLUSH_DATA;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: one SKID=0 and one SKID=1 instance,
// each compared every cycle against a queue-based reference model.
module tb_pipe_stage;

  localparam logic [31:0] FD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n, flush, pause, out_ready;
  logic        iv0, iv1;
  logic [31:0] id0, id1;
  logic        ir0, ir1, ov0, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  oc0, oc1;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        acc0_last, acc1_last;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(32), .FLUSH_DATA(FD), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pause(pause),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(oc0)
  );

  pipe_stage #(.WIDTH(32), .FLUSH_DATA(FD), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pause(pause),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare both instances against the model before the edge, then advance the model.
  task automatic cycle();
    logic e_ov0, e_ov1, e_ir0, e_ir1, acc0, acc1, rel0, rel1;
    @(negedge clk);
    e_ov0 = (q0.size() > 0) && !pause && !flush && rst_n;
    e_ov1 = (q1.size() > 0) && !pause && !flush && rst_n;
    e_ir0 = ((q0.size() == 0) || out_ready) && !pause && !flush;
    e_ir1 = (q1.size() < 2) && !pause && !flush;
    chk("ov0",  {31'b0, ov0}, {31'b0, e_ov0});
    chk("ir0",  {31'b0, ir0}, {31'b0, e_ir0});
    chk("od0",  od0, (q0.size() > 0) ? q0[0] : FD);
    chk("occ0", {30'b0, oc0}, 32'(q0.size()));
    chk("ov1",  {31'b0, ov1}, {31'b0, e_ov1});
    chk("ir1",  {31'b0, ir1}, {31'b0, e_ir1});
    chk("od1",  od1, (q1.size() > 0) ? q1[0] : FD);
    chk("occ1", {30'b0, oc1}, 32'(q1.size()));
    acc0 = iv0 && e_ir0;
    acc1 = iv1 && e_ir1;
    rel0 = e_ov0 && out_ready;
    rel1 = e_ov1 && out_ready;
    @(posedge clk);
    #1;
    if (!rst_n || flush) begin
      q0.delete();
      q1.delete();
      acc0 = 1'b0;
      acc1 = 1'b0;
    end else if (!pause) begin
      if (rel0) void'(q0.pop_front());
      if (acc0) q0.push_back(id0);
      if (rel1) void'(q1.pop_front());
      if (acc1) q1.push_back(id1);
    end
    acc0_last = acc0;
    acc1_last = acc1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pause = 1'b0; out_ready = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; id0 = '0; id1 = '0;
    acc0_last = 1'b0; acc1_last = 1'b0;

    // Reset and idle
    cycle();
    cycle();
    chk("rst_od1",  od1, FD);
    chk("rst_occ1", {30'b0, oc1}, 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("idle_ir1", {31'b0, ir1}, 32'd1);
    chk("idle_ir0", {31'b0, ir0}, 32'd1);

    // Streaming 1..4 into both instances
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      iv0 = 1'b1; id0 = 32'(v);
      iv1 = 1'b1; id1 = 32'(v);
      cycle();
      chk("stream_od1", od1, 32'(v));
      chk("stream_od0", od0, 32'(v));
    end
    iv0 = 1'b0; iv1 = 1'b0;
    cycle();
    cycle();

    // Back-pressure on the skid instance
    iv1 = 1'b1; id1 = 32'd1; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; id1 = 32'd2;
    cycle();
    chk("bp_occ", {30'b0, oc1}, 32'd2);
    chk("bp_ir",  {31'b0, ir1}, 32'd0);
    id1 = 32'd3;
    cycle();
    iv1 = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_second", od1, 32'd2);
    cycle();
    cycle();

    // SKID=0 simultaneous accept and release
    iv0 = 1'b1; id0 = 32'd5; out_ready = 1'b0;
    cycle();
    id0 = 32'd6; out_ready = 1'b1;
    cycle();
    chk("sim_od0",  od0, 32'd6);
    chk("sim_occ0", {30'b0, oc0}, 32'd1);
    iv0 = 1'b0;
    cycle();

    // Pause holding 7
    iv0 = 1'b1; id0 = 32'd7; out_ready = 1'b0;
    cycle();
    iv0 = 1'b0; pause = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("pause_ov0", {31'b0, ov0}, 32'd0);
    pause = 1'b0;
    #1;
    chk("unpause_od0", od0, 32'd7);
    chk("unpause_ov0", {31'b0, ov0}, 32'd1);
    cycle();

    // Flush with a full skid stage, then flush together with pause
    for (int rep = 0; rep < 2; rep++) begin
      out_ready = 1'b0;
      iv1 = 1'b1; id1 = 32'd8;
      cycle();
      id1 = 32'd9;
      cycle();
      id1 = 32'd10; flush = 1'b1; pause = (rep == 1);
      cycle();
      flush = 1'b0; pause = 1'b0; iv1 = 1'b0;
      chk("flush_occ1", {30'b0, oc1}, 32'd0);
      chk("flush_od1",  od1, FD);
    end

    // Asynchronous reset in the middle of traffic
    iv0 = 1'b1; id0 = 32'h11; iv1 = 1'b1; id1 = 32'h22;
    cycle();
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("arst_occ1", {30'b0, oc1}, 32'd0);
    chk("arst_od0",  od0, FD);
    #2;
    rst_n = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0;
    cycle();

    // Random traffic; upstream holds each payload until accepted
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom % 20) == 0;
      pause     = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      if (!iv0 || acc0_last) begin iv0 = ($urandom % 4) != 0; id0 = $urandom; end
      if (!iv1 || acc1_last) begin iv1 = ($urandom % 4) != 0; id1 = $urandom; end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
